// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a 1-cycle synchronous imem and
// buffers {PC+4, instr} pairs in a FIFO for ID. Redirects flush everything and restart at the target.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          CNT_W    = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             redirect_valid_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic             id_valid_o,
    output logic [31:0]      id_instr_o,
    output logic [31:0]      id_pc4_o,
    input  logic             id_ready_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc4_mem_q   [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      tag_q;
    logic             inflight_q;

    logic             credit_ok;
    logic             push, pop;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // An in-flight fetch already owns a slot, so it counts against the credit.
    assign credit_ok = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < (CNT_W+1)'(DEPTH);

    assign imem_req_o  = !reset_i && !redirect_valid_i && credit_ok;
    assign imem_addr_o = fetch_pc_q;

    assign id_valid_o = !reset_i && !redirect_valid_i && (count_q != '0);
    assign id_instr_o = id_valid_o ? instr_mem_q[head_q] : 32'h0;
    assign id_pc4_o   = id_valid_o ? pc4_mem_q[head_q]   : 32'h0;
    assign count_o    = reset_i ? '0 : count_q;

    assign pop  = id_valid_o && id_ready_i;
    assign push = inflight_q && !redirect_valid_i && !reset_i;

    assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    assign fetch_pc_d = fetch_pc_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            tag_q      <= 32'h0;
            inflight_q <= 1'b0;
        end else if (redirect_valid_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            count_q    <= count_d;
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                fetch_pc_q <= fetch_pc_d;
                tag_q      <= fetch_pc_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc4_mem_q[tail_q]   <= tag_q;
            instr_mem_q[tail_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the prefetch behaviour.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        reset_i, redirect_valid_i, id_ready_i;
    logic [31:0] redirect_pc_i, imem_rdata_i;
    logic        imem_req_o, id_valid_o;
    logic [31:0] imem_addr_o, id_instr_o, id_pc4_o;
    logic [2:0]  count_o;

    always #5 clk_i = ~clk_i;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .CNT_W(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc4_o(id_pc4_o),
        .id_ready_i(id_ready_i), .count_o(count_o)
    );

    int checks = 0;
    int failures = 0;

    // Model: FIFO contents as {pc4, instr}, next fetch address, outstanding fetch.
    logic [63:0] mq[$];
    logic [31:0] m_fetch_pc;
    logic        m_infl;
    logic [31:0] m_infl_addr;
    logic [31:0] next_rdata;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_pc4, o_count;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          e_req, e_valid;
        logic [63:0] head;
        e_req   = 1'b0;
        e_valid = 1'b0;
        reset_i          = rst;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        id_ready_i       = rdy;
        imem_rdata_i     = next_rdata;
        #4;
        o_req   = imem_req_o;
        o_valid = id_valid_o;
        o_addr  = imem_addr_o;
        o_instr = id_instr_o;
        o_pc4   = id_pc4_o;
        o_count = 32'(count_o);
        if (rst) begin
            chk("rst_req",   32'(o_req),   32'h0);
            chk("rst_valid", 32'(o_valid), 32'h0);
            chk("rst_count", o_count,      32'h0);
            chk("rst_instr", o_instr,      32'h0);
            chk("rst_pc4",   o_pc4,        32'h0);
        end else begin
            e_req   = !rv && ((mq.size() + int'(m_infl)) < DEPTH);
            e_valid = (mq.size() != 0) && !rv;
            chk("req",   32'(o_req),   32'(e_req));
            chk("valid", 32'(o_valid), 32'(e_valid));
            chk("count", o_count,      32'(mq.size()));
            if (e_req) chk("addr", o_addr, m_fetch_pc);
            if (e_valid) begin
                head = mq[0];
                chk("pc4",   o_pc4,   head[63:32]);
                chk("instr", o_instr, head[31:0]);
            end
        end
        next_rdata = e_req ? instr_of(m_fetch_pc) : $urandom();
        if (rst) begin
            mq.delete();
            m_fetch_pc = 32'h0;
            m_infl     = 1'b0;
        end else if (rv) begin
            mq.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_infl     = 1'b0;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back({m_infl_addr + 32'd4, instr_of(m_infl_addr)});
            m_infl = e_req;
            if (e_req) begin
                m_infl_addr = m_fetch_pc;
                m_fetch_pc  = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
        id_ready_i = 1'b0; imem_rdata_i = 32'h0; next_rdata = 32'h0;
        m_fetch_pc = 32'h0; m_infl = 1'b0; m_infl_addr = 32'h0;
        @(posedge clk_i);
        #1;
        repeat (2) cycle(1, 0, 32'h0, 1);

        // Sequential fetch after reset, first delivery two cycles after first request
        cycle(0, 0, 32'h0, 1);
        chk("t1_addr0", o_addr, 32'h0);
        chk("t1_valid0", 32'(o_valid), 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t1_addr1", o_addr, 32'h4);
        cycle(0, 0, 32'h0, 1);
        chk("t1_addr2", o_addr, 32'h8);
        chk("t1_valid2", 32'(o_valid), 32'h1);
        chk("t1_pc4_2", o_pc4, 32'h4);
        repeat (5) cycle(0, 0, 32'h0, 1);
        chk("t1_stream", 32'(o_valid), 32'h1);

        // Backpressure fills the FIFO and stalls fetch; head is held
        cycle(1, 0, 32'h0, 0);
        repeat (10) cycle(0, 0, 32'h0, 0);
        chk("t2_count_full", o_count, 32'h4);
        chk("t2_req_stall", 32'(o_req), 32'h0);
        chk("t2_head_pc4", o_pc4, 32'h4);
        repeat (8) cycle(0, 0, 32'h0, 1);

        // Redirect while full
        repeat (6) cycle(0, 0, 32'h0, 0);
        chk("t3_full", o_count, 32'h4);
        cycle(0, 1, 32'h40, 1);
        chk("t3_valid_R", 32'(o_valid), 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t3_req_R1", 32'(o_req), 32'h1);
        chk("t3_addr_R1", o_addr, 32'h40);
        chk("t3_valid_R1", 32'(o_valid), 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t3_valid_R2", 32'(o_valid), 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t3_valid_R3", 32'(o_valid), 32'h1);
        chk("t3_pc4_R3", o_pc4, 32'h44);

        // Redirect right after a request drops the returning word; low target bits ignored
        repeat (3) cycle(0, 0, 32'h0, 1);
        chk("t4_req_before", 32'(o_req), 32'h1);
        cycle(0, 1, 32'h103, 1);
        cycle(0, 0, 32'h0, 1);
        chk("t4_addr_R1", o_addr, 32'h100);
        cycle(0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 1);
        chk("t4_pc4_R3", o_pc4, 32'h104);

        // Fetch address wraps at the top of the address space
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 32'h0, 1);
        chk("t5_addr_R1", o_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 32'h0, 1);
        chk("t5_addr_R2", o_addr, 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t5_valid_R3", 32'(o_valid), 32'h1);
        chk("t5_pc4_R3", o_pc4, 32'h0);
        cycle(0, 0, 32'h0, 1);
        chk("t5_pc4_R4", o_pc4, 32'h4);

        // Reset with three buffered entries and one fetch in flight
        cycle(1, 0, 32'h0, 0);
        repeat (5) cycle(0, 0, 32'h0, 0);
        chk("t6_count3", o_count, 32'h3);
        chk("t6_req0", 32'(o_req), 32'h0);
        cycle(1, 0, 32'h0, 0);
        cycle(0, 0, 32'h0, 0);
        chk("t6_count_after", o_count, 32'h0);
        chk("t6_valid_after", 32'(o_valid), 32'h0);
        chk("t6_req_after", 32'(o_req), 32'h1);
        chk("t6_addr_after", o_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 15) == 0),
                  $urandom(),
                  ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
